// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/count/flag controller for a single-clock FIFO whose
// storage lives outside this block.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   reset        - synchronous active-high reset, overrides everything else
//   wr           - push request
//   rd           - pop request (consumes the entry at r_addr)
//   clr_err      - clears the sticky overflow/underflow flags
//   we           - storage write enable (an accepted push this cycle)
//   w_addr       - storage write address (write pointer)
//   r_addr       - storage read address (read pointer, head of queue)
//   full/empty   - registered occupancy flags, aligned with count
//   almost_full  - count >= AF_LEVEL
//   almost_empty - count <= AE_LEVEL
//   count        - current occupancy, 0..2**ADDR_WIDTH
//   overflow     - sticky: push attempted while full without a pop
//   underflow    - sticky: pop attempted while empty
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int AF_LEVEL   = 120,
  parameter int AE_LEVEL   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push_ok;
  logic                  pop_ok;

  // A push into a full FIFO is still accepted when a pop frees the head slot
  // in the same cycle; a pop from an empty FIFO never is.
  assign push_ok = wr & (~full_q | rd);
  assign pop_ok  = rd & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    // Pointers wrap naturally at 2**ADDR_WIDTH.
    if (push_ok) wptr_d = wptr_q + PTR_ONE;
    if (pop_ok)  rptr_d = rptr_q + PTR_ONE;

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Flags are computed from the next count so they change in the same
    // cycle as count itself.
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);

    // A new error wins over a simultaneous clear.
    ovf_d = (ovf_q & ~clr_err) | (wr & full_q & ~rd);
    unf_d = (unf_q & ~clr_err) | (rd & empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage must not be written in a reset cycle, the push is discarded.
  assign we           = push_ok & ~reset;
  assign w_addr       = wptr_q;
  assign r_addr       = rptr_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;
  localparam int AW = 7;
  localparam int D  = 128;
  localparam int AF = 120;
  localparam int AE = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic          clr_err = 1'b0;
  logic          we;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
    .we(we), .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: a queue of stored data plus push/pop totals.
  int q[$];
  int pushes = 0;
  int pops   = 0;
  bit m_ovf  = 1'b0;
  bit m_unf  = 1'b0;

  // Storage array emulated by the bench, driven by the DUT's we/addresses.
  logic [15:0] mem [D];

  bit we_obs, exp_we, exp_pop;
  int rdata_obs, exp_rdata;

  // Apply one cycle of inputs, capture combinational outputs, then advance
  // the model to match the rising edge.
  task automatic drive(input bit w, input bit r, input bit c, input bit rs);
    int  sz;
    int  d;
    bit  push_ok, pop_ok;
    wr = w; rd = r; clr_err = c; reset = rs;
    #1;
    sz      = q.size();
    pop_ok  = !rs && r && (sz > 0);
    push_ok = !rs && w && ((sz < D) || r);
    we_obs  = we;
    exp_we  = push_ok;
    exp_pop = pop_ok;
    rdata_obs = int'(mem[r_addr]);
    d = int'($urandom_range(0, 65535));
    if (we === 1'b1) mem[w_addr] = 16'(d);
    @(posedge clk);
    if (rs) begin
      q.delete(); pushes = 0; pops = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_ovf = (m_ovf && !c) || (w && !r && sz == D);
      m_unf = (m_unf && !c) || (r && sz == 0);
      if (pop_ok) begin exp_rdata = q.pop_front(); pops++; end
      if (push_ok) begin q.push_back(d); pushes++; end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    total++; if (we_obs !== 1'b0) $display("FAIL reset_we got=%0b exp=0", we_obs); else passed++;
    total++; if (int'(count) !== 0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%0b exp=1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got=%0b exp=0", full); else passed++;
    total++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got=%0b exp=1", almost_empty); else passed++;
    total++; if (almost_full !== 1'b0) $display("FAIL reset_af got=%0b exp=0", almost_full); else passed++;
    total++; if (int'(w_addr) !== 0 || int'(r_addr) !== 0) $display("FAIL reset_ptrs got=%0d/%0d exp=0/0", w_addr, r_addr); else passed++;
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL reset_err got=%0b%0b exp=00", overflow, underflow); else passed++;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= D; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      total++; if (int'(count) !== k) $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, count, k); else passed++;
      total++; if (almost_full !== (k >= AF)) $display("FAIL fill_af k=%0d got=%0b exp=%0b", k, almost_full, (k >= AF)); else passed++;
      total++; if (almost_empty !== (k <= AE)) $display("FAIL fill_ae k=%0d got=%0b exp=%0b", k, almost_empty, (k <= AE)); else passed++;
      total++; if (full !== (k == D)) $display("FAIL fill_full k=%0d got=%0b exp=%0b", k, full, (k == D)); else passed++;
      total++; if (empty !== 1'b0) $display("FAIL fill_empty k=%0d got=%0b exp=0", k, empty); else passed++;
    end
    total++; if (int'(w_addr) !== 0) $display("FAIL fill_wrap got=%0d exp=0", w_addr); else passed++;
  endtask

  task automatic test_overflow();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (we_obs !== 1'b0) $display("FAIL ovf_we got=%0b exp=0", we_obs); else passed++;
    total++; if (int'(count) !== D) $display("FAIL ovf_count got=%0d exp=%0d", count, D); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set got=%0b exp=1", overflow); else passed++;
    total++; if (int'(w_addr) !== 0) $display("FAIL ovf_waddr got=%0d exp=0", w_addr); else passed++;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clr got=%0b exp=0", overflow); else passed++;
  endtask

  task automatic test_full_rw();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      total++; if (we_obs !== 1'b1) $display("FAIL fullrw_we k=%0d got=%0b exp=1", k, we_obs); else passed++;
      total++; if (rdata_obs !== exp_rdata) $display("FAIL fullrw_data k=%0d got=%0h exp=%0h", k, rdata_obs, exp_rdata); else passed++;
    end
    total++; if (int'(count) !== D || full !== 1'b1) $display("FAIL fullrw_count got=%0d/%0b exp=%0d/1", count, full, D); else passed++;
    total++; if (int'(r_addr) !== 10) $display("FAIL fullrw_raddr got=%0d exp=10", r_addr); else passed++;
    total++; if (int'(w_addr) !== 10) $display("FAIL fullrw_waddr got=%0d exp=10", w_addr); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL fullrw_ovf got=%0b exp=0", overflow); else passed++;
  endtask

  task automatic test_empty_rw();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (we_obs !== 1'b1) $display("FAIL emptyrw_we got=%0b exp=1", we_obs); else passed++;
    total++; if (int'(count) !== 1 || empty !== 1'b0) $display("FAIL emptyrw_count got=%0d/%0b exp=1/0", count, empty); else passed++;
    total++; if (underflow !== 1'b1) $display("FAIL emptyrw_unf got=%0b exp=1", underflow); else passed++;
    total++; if (int'(r_addr) !== 0) $display("FAIL emptyrw_raddr got=%0d exp=0", r_addr); else passed++;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (rdata_obs !== exp_rdata) $display("FAIL emptyrw_data got=%0h exp=%0h", rdata_obs, exp_rdata); else passed++;
    total++; if (empty !== 1'b1 || int'(r_addr) !== 1) $display("FAIL emptyrw_pop got=%0b/%0d exp=1/1", empty, r_addr); else passed++;
    // Pop from empty together with clr_err: pointer holds, flag stays set.
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    total++; if (int'(r_addr) !== 1 || int'(count) !== 0) $display("FAIL emptyrd_hold got=%0d/%0d exp=1/0", r_addr, count); else passed++;
    total++; if (underflow !== 1'b1) $display("FAIL emptyrd_clrsame got=%0b exp=1", underflow); else passed++;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (underflow !== 1'b0) $display("FAIL emptyrd_clr got=%0b exp=0", underflow); else passed++;
  endtask

  task automatic test_latency();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (empty !== 1'b0) $display("FAIL lat_empty got=%0b exp=0", empty); else passed++;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (exp_pop !== 1'b1 || rdata_obs !== exp_rdata) $display("FAIL lat_data got=%0h exp=%0h", rdata_obs, exp_rdata); else passed++;
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 50; k++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (int'(count) !== 50) $display("FAIL rstmid_fill got=%0d exp=50", count); else passed++;
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    total++; if (we_obs !== 1'b0) $display("FAIL rstmid_we got=%0b exp=0", we_obs); else passed++;
    total++; if (int'(count) !== 0 || empty !== 1'b1) $display("FAIL rstmid_count got=%0d/%0b exp=0/1", count, empty); else passed++;
    total++; if (int'(w_addr) !== 0 || int'(r_addr) !== 0) $display("FAIL rstmid_ptrs got=%0d/%0d exp=0/0", w_addr, r_addr); else passed++;
  endtask

  task automatic test_random();
    int pw, pr;
    bit w, r, c, rs;
    for (int i = 0; i < 10000; i++) begin
      // Phases bias toward filling, draining, balanced and saturated traffic.
      case ((i / 1250) % 4)
        0:       begin pw = 70; pr = 30; end
        1:       begin pw = 30; pr = 70; end
        2:       begin pw = 50; pr = 50; end
        default: begin pw = 90; pr = 85; end
      endcase
      w  = ($urandom_range(0, 99) < pw);
      r  = ($urandom_range(0, 99) < pr);
      c  = ($urandom_range(0, 31) == 0);
      rs = ($urandom_range(0, 2999) == 0);
      drive(w, r, c, rs);
      total++; if (we_obs !== exp_we) $display("FAIL rnd_we cyc=%0d got=%0b exp=%0b", i, we_obs, exp_we); else passed++;
      if (exp_pop) begin
        total++; if (rdata_obs !== exp_rdata) $display("FAIL rnd_data cyc=%0d got=%0h exp=%0h", i, rdata_obs, exp_rdata); else passed++;
      end
      total++; if (int'(count) !== q.size()) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, q.size()); else passed++;
      total++; if (full !== (q.size() == D)) $display("FAIL rnd_full cyc=%0d got=%0b exp=%0b", i, full, (q.size() == D)); else passed++;
      total++; if (empty !== (q.size() == 0)) $display("FAIL rnd_empty cyc=%0d got=%0b exp=%0b", i, empty, (q.size() == 0)); else passed++;
      total++; if (almost_full !== (q.size() >= AF)) $display("FAIL rnd_af cyc=%0d got=%0b exp=%0b", i, almost_full, (q.size() >= AF)); else passed++;
      total++; if (almost_empty !== (q.size() <= AE)) $display("FAIL rnd_ae cyc=%0d got=%0b exp=%0b", i, almost_empty, (q.size() <= AE)); else passed++;
      total++; if (int'(w_addr) !== pushes % D) $display("FAIL rnd_waddr cyc=%0d got=%0d exp=%0d", i, w_addr, pushes % D); else passed++;
      total++; if (int'(r_addr) !== pops % D) $display("FAIL rnd_raddr cyc=%0d got=%0d exp=%0d", i, r_addr, pops % D); else passed++;
      total++; if (overflow !== m_ovf) $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", i, overflow, m_ovf); else passed++;
      total++; if (underflow !== m_unf) $display("FAIL rnd_unf cyc=%0d got=%0b exp=%0b", i, underflow, m_unf); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_latency();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
